// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants, FSM state type and IEEE-754 single-precision
// field helpers for the sequential floating-point subtractor.
package fpu_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int FRAC_W  = MAN_W + 1;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } fsub_state_t;

  function automatic logic float_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [EXP_W-1:0] float_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] float_man(input logic [31:0] f);
    return f[22:0];
  endfunction

  // Zero magnitude regardless of the sign bit.
  function automatic logic float_is_zero(input logic [31:0] f);
    return (f[30:0] == 31'd0);
  endfunction

endpackage

// File: rtl/fp_lzc24.sv
// fp_lzc24: 24-bit leading-zero counter for the single-cycle normaliser.
// An all-zero input reports 24.
module fp_lzc24 (
  input  logic [fpu_pkg::FRAC_W-1:0] value,
  output logic [4:0]                 count
);

  // Scan from LSB to MSB so the highest set bit has the final say.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < fpu_pkg::FRAC_W; i++) begin
      if (value[i]) begin
        count = 5'(fpu_pkg::FRAC_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/floating_subtractor_seq.sv
// floating_subtractor_seq: multi-cycle IEEE-754 single-precision A - B with
// valid/ready handshakes. Pipeline of FSM states IDLE -> ALIGN -> ADD ->
// NORM -> DONE, truncating arithmetic, flush-to-zero on exponent underflow.
// Build option: define FSUB_FAST_NORM_EN for a one-cycle NORM using a
// leading-zero counter and barrel shift; default is a 1-bit-per-cycle shifter.
module floating_subtractor_seq #(
  parameter int EXP_W = fpu_pkg::EXP_W,
  parameter int MAN_W = fpu_pkg::MAN_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result
);
  import fpu_pkg::*;

  localparam int DW = EXP_W + MAN_W + 1;
  localparam int FW = MAN_W + 1;
  localparam logic [EXP_W-1:0] FW_E     = EXP_W'(FW);
  localparam logic [EXP_W-1:0] EXP_ALL1 = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] EXP_TWO  = EXP_W'(2);

  fsub_state_t      state;
  logic [DW-1:0]    a_reg;
  logic [DW-1:0]    b_reg;      // already carries the inverted sign (B')
  logic [DW-1:0]    result_reg;
  logic [FW-1:0]    fa_reg;
  logic [FW-1:0]    fb_reg;
  logic [FW-1:0]    frac_reg;
  logic [EXP_W-1:0] exp_reg;
  logic             sign_reg;
  logic             a_big_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  // Unpack and alignment terms, evaluated from the latched operands.
  logic [EXP_W-1:0] exp_a, exp_b, diff_ab, diff_ba, exp_max;
  logic [FW-1:0]    man_a, man_b, man_a_al, man_b_al;
  logic             zero_a, zero_b, a_big;

  // Add/subtract terms, evaluated from the aligned fractions.
  logic [FW:0]      sum;
  logic [FW-1:0]    mag_diff;
  logic [EXP_W-1:0] exp_inc;
  logic             same_sign;

  // Unpack both operands, pick the common exponent and right-align the smaller one.
  always_comb begin
    exp_a    = a_reg[DW-2 -: EXP_W];
    exp_b    = b_reg[DW-2 -: EXP_W];
    man_a    = {1'b1, a_reg[MAN_W-1:0]};
    man_b    = {1'b1, b_reg[MAN_W-1:0]};
    zero_a   = (a_reg[DW-2:0] == '0);
    zero_b   = (b_reg[DW-2:0] == '0);
    diff_ab  = exp_a - exp_b;
    diff_ba  = exp_b - exp_a;
    exp_max  = exp_a;
    man_a_al = man_a;
    man_b_al = man_b;
    if (exp_a >= exp_b) begin
      man_b_al = (diff_ab >= FW_E) ? '0 : (man_b >> diff_ab);
    end else begin
      exp_max  = exp_b;
      man_a_al = (diff_ba >= FW_E) ? '0 : (man_a >> diff_ba);
    end
    // Magnitude order on unshifted values; a full tie favours A.
    a_big = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a >= man_b));
  end

  // Effective add or magnitude subtract of the aligned fractions.
  always_comb begin
    sum       = {1'b0, fa_reg} + {1'b0, fb_reg};
    mag_diff  = a_big_reg ? (fa_reg - fb_reg) : (fb_reg - fa_reg);
    exp_inc   = exp_reg + 1'b1;
    same_sign = (a_reg[DW-1] == b_reg[DW-1]);
  end

`ifdef FSUB_FAST_NORM_EN
  logic [4:0]       lz_count;
  logic [FW-1:0]    norm_frac;
  logic [EXP_W-1:0] norm_exp;
  logic             norm_flush;

  fp_lzc24 u_lzc (
    .value (frac_reg),
    .count (lz_count)
  );

  // Whole normalisation in one step; flush when the shift would take exp below 1.
  always_comb begin
    norm_frac  = frac_reg << lz_count;
    norm_exp   = exp_reg - EXP_W'(lz_count);
    norm_flush = (lz_count != 5'd0) && (EXP_W'(lz_count) >= exp_reg);
  end
`endif

  // Control FSM and datapath registers; all outputs come straight from here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      result_reg    <= FP_ZERO;
      a_reg         <= '0;
      b_reg         <= '0;
      fa_reg        <= '0;
      fb_reg        <= '0;
      frac_reg      <= '0;
      exp_reg       <= '0;
      sign_reg      <= 1'b0;
      a_big_reg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= A;
            b_reg        <= {~B[DW-1], B[DW-2:0]};
            in_ready_reg <= 1'b0;
            state        <= ALIGN;
          end
        end
        ALIGN: begin
          if (zero_b) begin
            result_reg    <= a_reg;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else if (zero_a) begin
            result_reg    <= b_reg;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            exp_reg   <= exp_max;
            fa_reg    <= man_a_al;
            fb_reg    <= man_b_al;
            a_big_reg <= a_big;
            state     <= ADD;
          end
        end
        ADD: begin
          if (same_sign) begin
            sign_reg <= a_reg[DW-1];
            if (sum[FW]) begin
              if (exp_inc == EXP_ALL1) begin
                result_reg    <= {a_reg[DW-1], EXP_ALL1, {MAN_W{1'b0}}};
                out_valid_reg <= 1'b1;
                state         <= DONE;
              end else begin
                frac_reg <= sum[FW:1];
                exp_reg  <= exp_inc;
                state    <= NORM;
              end
            end else begin
              frac_reg <= sum[FW-1:0];
              state    <= NORM;
            end
          end else begin
            sign_reg <= a_big_reg ? a_reg[DW-1] : b_reg[DW-1];
            frac_reg <= mag_diff;
            state    <= NORM;
          end
        end
        NORM: begin
`ifdef FSUB_FAST_NORM_EN
          if (frac_reg == '0) begin
            result_reg <= FP_ZERO;
          end else if (norm_flush) begin
            result_reg <= {sign_reg, {(DW-1){1'b0}}};
          end else begin
            result_reg <= {sign_reg, norm_exp, norm_frac[MAN_W-1:0]};
          end
          out_valid_reg <= 1'b1;
          state         <= DONE;
`else
          if (frac_reg == '0) begin
            // Exact cancellation always yields +0.
            result_reg    <= FP_ZERO;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else if (frac_reg[FW-1]) begin
            result_reg    <= {sign_reg, exp_reg, frac_reg[MAN_W-1:0]};
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else if (exp_reg < EXP_TWO) begin
            // No exponent headroom left for another shift: flush to signed zero.
            result_reg    <= {sign_reg, {(DW-1){1'b0}}};
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            frac_reg <= frac_reg << 1;
            exp_reg  <= exp_reg - 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;

endmodule

// File: tb/tb_floating_subtractor_seq.sv
// tb_floating_subtractor_seq: directed vector table, handshake/reset sequences
// and randomized operands checked against an arithmetic reference model.
module tb_floating_subtractor_seq;

`ifdef FSUB_FAST_NORM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  floating_subtractor_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (op_a),
    .B         (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat_slow;
    int          lat_fast;
  } vec_t;

  vec_t vecs[11];

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: exact aligned signed-integer arithmetic on the significands,
  // then normalisation by leading-one position; latency from the timing rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    logic [31:0] bn;
    int ea, eb, e, va, vb, s, mag, msb, k;
    logic sg;
    bn = b ^ 32'h8000_0000;
    lat = 2;
    if (b[30:0] == 31'd0) begin r = a; return; end
    if (a[30:0] == 31'd0) begin r = bn; return; end
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    e  = (ea > eb) ? ea : eb;
    va = int'({1'b1, a[22:0]});
    vb = int'({1'b1, b[22:0]});
    va = (e - ea >= 24) ? 0 : (va >>> (e - ea));
    vb = (e - eb >= 24) ? 0 : (vb >>> (e - eb));
    s  = (a[31] ? -va : va) + (bn[31] ? -vb : vb);
    lat = 4;
    if (s == 0) begin r = 32'h0; return; end
    sg  = (s < 0);
    mag = sg ? -s : s;
    if (mag >= (1 << 24)) begin
      mag = mag >>> 1;
      e   = e + 1;
      if (e == 255) begin
        r = {sg, 8'hFF, 23'h0};
        lat = 3;
        return;
      end
    end
    msb = $clog2(mag + 1) - 1;
    k   = 23 - msb;
    if (k > e - 1) begin
      r = {sg, 31'h0};
      lat = FAST ? 4 : 4 + (e - 1);
      return;
    end
    mag = mag << k;
    e   = e - k;
    r   = {sg, e[7:0], mag[22:0]};
    lat = FAST ? 4 : 4 + k;
  endfunction

  // One full transaction: offer operands, count edges to out_valid, then consume.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    chk32("in_ready_idle", {31'h0, in_ready}, 32'h1);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("op %h - %h -> %h latency %0d", a, b, res, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, exp_r;
    int lat, exp_lat, ea, eb, mode;
    logic [22:0] ma, mb;

    vecs[0]  = '{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, 4};
    vecs[1]  = '{32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 6, 4};
    vecs[2]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4, 4};
    vecs[3]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4, 4};
    vecs[4]  = '{32'h0000_0000, 32'h40A0_0000, 32'hC0A0_0000, 2, 2};
    vecs[5]  = '{32'h40A0_0000, 32'h8000_0000, 32'h40A0_0000, 2, 2};
    vecs[6]  = '{32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 3, 3};
    vecs[7]  = '{32'h0100_0001, 32'h0100_0000, 32'h0000_0000, 5, 4};
    vecs[8]  = '{32'h0100_0000, 32'h0100_0001, 32'h8000_0000, 5, 4};
    vecs[9]  = '{32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 4, 4};
    vecs[10] = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 2, 2};

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk32("reset_in_ready", {31'h0, in_ready}, 32'h1);
    chk32("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk32("reset_result", result, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, r, lat);
      chk32($sformatf("vec%0d_result", i), r, vecs[i].res);
      chk_int($sformatf("vec%0d_latency", i), lat, FAST ? vecs[i].lat_fast : vecs[i].lat_slow);
      chk32($sformatf("vec%0d_idle_after", i), {30'h0, in_ready, out_valid}, 32'h2);
    end

    // Stall in DONE for 10 cycles while junk operands are offered
    op_a = 32'h4040_0000;
    op_b = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      op_a = $urandom;
      op_b = $urandom;
      chk32("stall_result", result, 32'h4000_0000);
      chk32("stall_flags", {30'h0, in_ready, out_valid}, 32'h1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk32("stall_release_flags", {30'h0, in_ready, out_valid}, 32'h2);
    $display("op 40400000 - 3f800000 stalled 10 cycles -> %h", 32'h4000_0000);

    // Reset while the operation is in NORM
    op_a = 32'h3F80_0000;
    op_b = 32'h3F40_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk32("midnorm_reset_flags", {30'h0, in_ready, out_valid}, 32'h2);
    chk32("midnorm_reset_result", result, 32'h0);
    @(posedge clk); #1;
    chk32("midnorm_reset_idle", {30'h0, in_ready, out_valid}, 32'h2);
    $display("op 3f800000 - 3f400000 aborted by reset in NORM");
    run_op(32'h4100_0000, 32'h3FC0_0000, r, lat);
    model(32'h4100_0000, 32'h3FC0_0000, exp_r, exp_lat);
    chk32("post_reset_result", r, exp_r);
    chk_int("post_reset_latency", lat, exp_lat);

    // Randomized operands against the reference model
    for (int n = 0; n < 160; n++) begin
      mode = int'($urandom_range(0, 5));
      ea = int'($urandom_range(1, 254));
      ma = 23'($urandom);
      mb = 23'($urandom);
      case (mode)
        0: eb = ea;
        1: begin
          eb = ea + int'($urandom_range(0, 6)) - 3;
          if (eb < 1) eb = 1;
          if (eb > 254) eb = 254;
        end
        2: eb = int'($urandom_range(1, 254));
        3: begin
          eb = ea;
          mb = ma ^ 23'($urandom_range(0, 255));
        end
        4: begin
          ea = int'($urandom_range(1, 3));
          eb = ea;
          mb = ma ^ 23'($urandom_range(0, 15));
        end
        default: eb = ea + 1 > 254 ? 254 : ea + 1;
      endcase
      op_a = {1'($urandom), ea[7:0], ma};
      op_b = {1'($urandom), eb[7:0], mb};
      if (mode == 5 && n % 2 == 0) op_a[30:0] = 31'h0;
      if (mode == 5 && n % 2 == 1) op_b[30:0] = 31'h0;
      model(op_a, op_b, exp_r, exp_lat);
      run_op(op_a, op_b, r, lat);
      chk32($sformatf("rand%0d_result", n), r, exp_r);
      chk_int($sformatf("rand%0d_latency", n), lat, exp_lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/floating_subtractor_seq.md
Name: floating_subtractor_seq

Overview:
- Multi-cycle IEEE-754 single-precision subtractor (result = A - B); the counterpart of the team's combinational floating-point adder.
- Same unpack/align/normalize datapath, but registered into an FSM with valid/ready handshakes on both sides.
- Normalization uses an iterative 1-bit-per-cycle left shifter instead of a wide priority mux.
- Sits in the FPU next to the adder, feeding the accumulator/activation path.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width; the fraction is MAN_W+1 bits with the hidden 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands A/B valid
- in_ready  output  1  block can accept operands; high only in IDLE
- A  input  32  minuend
- B  input  32  subtrahend
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts result
- result  output  32  A - B, registered

Interface rule (already decided): one clock, clk; reset is synchronous and active-high on reset.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=32'h0. Reset at any state, including mid-NORM or DONE, aborts the operation with the same values on the next cycle.
- Accept: on a clk edge with in_valid & in_ready, latch A and B, compute effective B' = {~B[31], B[30:0]}, go to ALIGN. Operands are never sampled outside IDLE.
- Zero: an operand is zero when bits[30:0]==0.
  - A zero: result=B' and go straight to DONE.
  - B zero: result=A and go straight to DONE.
  - Both zero: result=A.
  - Zero-operand latency is 2 edges.
- ALIGN, 1 cycle:
  - exp = max(expA, expB); the smaller-exponent fraction is shifted right by the difference.
  - A difference >= 24 forces that fraction to 0.
  - Record the larger-magnitude operand: larger exponent wins; on a tie, larger fraction; on a full tie, A.
- ADD, 1 cycle:
  - Same effective sign: {cout, frac} = fA + fB; sign = A[31]. If cout, shift right 1 and exp+1.
  - Different sign: frac = big - small; sign = sign of the larger-magnitude operand.
- NORM, 1 cycle per step:
  - frac==0: result=32'h0 (exact cancellation gives +0), go to DONE.
  - frac[23]==1: go to DONE.
  - Otherwise shift frac left 1 and decrement exp; stay in NORM.
  - A net left shift of k bits takes k+1 NORM cycles.
- Exponent limits:
  - If exp==1 and a further left shift is required: flush to signed zero {sign, 31'b0}, go to DONE.
  - If the carry increment makes exp==255: result = {sign, 8'hFF, 23'b0} (infinity).
- Numeric rules: truncation only, no rounding. NaN/Inf/denormal inputs get no special handling; denormals are treated like normal operands (hidden 1 still applied).
- DONE: result={sign, exp, frac[22:0]}, registered. out_valid stays high and result stays stable until out_ready. The handshake edge returns to IDLE; in_ready rises the following cycle.
- Latency (accept edge to first out_valid cycle): 4+k edges, k = normalization shifts, 0..23.
- Throughput: one operation in flight; no back-to-back overlap.

Optional Feature:
- Macro: FSUB_FAST_NORM_EN.
- Defined: NORM completes in exactly 1 cycle using a 24-bit leading-one detector and barrel shift. Latency is fixed at 4 edges; same flush-to-zero/infinity rules apply.
- Undefined: iterative 1-bit NORM as described above.
- Numeric results are identical either way; only timing differs.

Decomposition:
- Shared package fpu_pkg:
  - constants EXP_W, MAN_W, FRAC_W=MAN_W+1, EXP_MAX=255
  - fsub_state_t enum {IDLE, ALIGN, ADD, NORM, DONE}
  - float field-slice helpers
  - zero/infinity constants
- Sub-module fp_lzc24: 24-bit leading-zero counter, instantiated only under FSUB_FAST_NORM_EN.

Test Plan:
- 3.0 - 1.0: A=0x40400000, B=0x3F800000 -> result 0x40000000; out_valid at accept+4.
- 1.0 - 0.75: A=0x3F800000, B=0x3F400000 -> 0x3E800000 after 2 shifts; out_valid at accept+6. With FSUB_FAST_NORM_EN: accept+4.
- 1.0 - (-1.0): B=0xBF800000 -> carry path, 0x40000000, latency 4.
- 1.0 - 1.0 -> 0x00000000.
- Zero operand: A=0x00000000, B=0x40A00000 -> 0xC0A00000, latency 2.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0.
  - Separate run: assert reset during NORM -> next cycle out_valid=0, in_ready=1, result=0.
  - A following operation then completes correctly.
